// File: rtl/tstream_dec_if.sv
// Handshake and result bundle between a temporal-stream producer and tstream_dec.
interface tstream_dec_if #(
  parameter int unsigned INWD = 8
);
  logic            start;
  logic            iBit;
  logic            iStop;
  logic [INWD:0]   oC;
  logic [INWD:0]   oLen;
  logic            oValid;
  logic            oBusy;

  modport master (
    output start, iBit, iStop,
    input  oC, oLen, oValid, oBusy
  );

  modport slave (
    input  start, iBit, iStop,
    output oC, oLen, oValid, oBusy
  );
endinterface

// File: rtl/tstream_dec.sv
// Temporal bitstream decoder: counts 1s over one window (iStop or 2^INWD cycles)
// and reports the count and window length with a one-cycle valid pulse.
module tstream_dec #(
  parameter int unsigned INWD = 8
) (
  input logic         clk,
  input logic         rst,
  tstream_dec_if.slave bus
);

  localparam logic [INWD:0] Win = {1'b1, {INWD{1'b0}}};
  localparam logic [INWD:0] One = {{INWD{1'b0}}, 1'b1};
  localparam logic [INWD:0] Zero = '0;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e        state_q, state_d;
  logic [INWD:0] ones_q, ones_d;
  logic [INWD:0] cyc_q, cyc_d;
  logic [INWD:0] oc_q, oc_d;
  logic [INWD:0] olen_q, olen_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ones_q  <= Zero;
      cyc_q   <= Zero;
      oc_q    <= Zero;
      olen_q  <= Zero;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      cyc_q   <= cyc_d;
      oc_q    <= oc_d;
      olen_q  <= olen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    cyc_d   = cyc_q;
    oc_d    = oc_q;
    olen_d  = olen_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StAcc;
          ones_d  = Zero;
          cyc_d   = Zero;
        end else begin
          state_d = StIdle;
        end
      end
      StAcc: begin
        if (bus.iStop) begin
          // The bit presented alongside iStop is outside the window.
          state_d = StDone;
          oc_d    = ones_q;
          olen_d  = cyc_q;
        end else begin
          ones_d = ones_q + {{INWD{1'b0}}, bus.iBit};
          cyc_d  = cyc_q + One;
          if (cyc_d == Win) begin
            state_d = StDone;
            oc_d    = ones_d;
            olen_d  = cyc_d;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.oC     = oc_q;
  assign bus.oLen   = olen_q;
  assign bus.oValid = (state_q == StDone);
  assign bus.oBusy  = (state_q == StAcc);

endmodule

// File: tb/tb_tstream_dec.sv
// Directed, table-driven bench for tstream_dec with INWD=8 (window of 256 cycles).
module tb_tstream_dec;
  localparam int unsigned INWD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tstream_dec_if #(.INWD(INWD)) bus ();

  tstream_dec #(.INWD(INWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    int    n;       // bits driven before termination
    int    mode;    // bit pattern selector
    bit    stop;    // terminate with iStop (iBit=1 on that cycle)
    bit    hold;    // keep start high throughout ACC
    int    exp_c;
    int    exp_len;
  } vec_t;

  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   prev_c  = 0;
  int   prev_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0 all ones, 1 alternating 1,0, 2 all zeros, 3 every third, 4 multiplier 128*128
  function automatic bit pat(input int mode, input int i);
    case (mode)
      0: return 1'b1;
      1: return (i % 2) == 0;
      2: return 1'b0;
      3: return (i % 3) == 0;
      4: return (i < 128) && ((((i + 1) * 128) >> 8) != ((i * 128) >> 8));
      default: return 1'b0;
    endcase
  endfunction

  // Entered at a negedge with the DUT in IDLE or DONE; leaves at the DONE negedge.
  task automatic do_window(input vec_t v);
    int early;
    early = 0;
    bus.start = 1'b1;
    @(negedge clk);
    check({v.name, " busy after start"}, int'(bus.oBusy), 1);
    check({v.name, " oC held at start"}, int'(bus.oC), prev_c);
    bus.start = v.hold;
    for (int i = 0; i < v.n; i++) begin
      bus.iBit  = pat(v.mode, i);
      bus.iStop = 1'b0;
      @(negedge clk);
      if (!(!v.stop && i == v.n - 1) && bus.oValid) early++;
    end
    if (v.stop) begin
      bus.iStop = 1'b1;
      bus.iBit  = 1'b1;
      @(negedge clk);
    end
    bus.iStop = 1'b0;
    bus.iBit  = 1'b0;
    bus.start = 1'b0;
    check({v.name, " early valid"}, early, 0);
    check({v.name, " valid"}, int'(bus.oValid), 1);
    check({v.name, " busy in done"}, int'(bus.oBusy), 0);
    check({v.name, " oC"}, int'(bus.oC), v.exp_c);
    check({v.name, " oLen"}, int'(bus.oLen), v.exp_len);
    prev_c   = v.exp_c;
    prev_len = v.exp_len;
  endtask

  task automatic after_done(input string name);
    @(negedge clk);
    check({name, " valid one cycle"}, int'(bus.oValid), 0);
    check({name, " idle not busy"}, int'(bus.oBusy), 0);
    check({name, " oLen held"}, int'(bus.oLen), prev_len);
  endtask

  initial begin
    vecs[0] = '{"full_ones", 256, 0, 1'b0, 1'b0, 256, 256};
    vecs[1] = '{"stop_alt", 100, 1, 1'b1, 1'b0, 50, 100};
    vecs[2] = '{"stop_first", 0, 0, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{"hold_start", 100, 1, 1'b1, 1'b1, 50, 100};
    vecs[4] = '{"third_stop", 30, 3, 1'b1, 1'b0, 10, 30};
    vecs[5] = '{"full_zeros", 256, 2, 1'b0, 1'b0, 0, 256};
    vecs[6] = '{"full_alt", 256, 1, 1'b0, 1'b0, 128, 256};
    vecs[7] = '{"mult_128x128", 256, 4, 1'b0, 1'b0, 64, 256};

    bus.start = 1'b0;
    bus.iBit  = 1'b0;
    bus.iStop = 1'b0;

    // Reset held 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom);
      bus.iBit  = 1'($urandom);
      bus.iStop = 1'($urandom);
      @(negedge clk);
      check("reset oC", int'(bus.oC), 0);
      check("reset oLen", int'(bus.oLen), 0);
      check("reset oValid", int'(bus.oValid), 0);
      check("reset oBusy", int'(bus.oBusy), 0);
    end
    bus.start = 1'b0;
    bus.iBit  = 1'b0;
    bus.iStop = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      do_window(vecs[k]);
      after_done(vecs[k].name);
    end

    // Reset after 40 counted ones discards the partial window and the results.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.iBit  = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.iBit = 1'b0;
    check("midrst oC", int'(bus.oC), 0);
    check("midrst oLen", int'(bus.oLen), 0);
    check("midrst oBusy", int'(bus.oBusy), 0);
    check("midrst oValid", int'(bus.oValid), 0);
    prev_c   = 0;
    prev_len = 0;
    @(negedge clk);
    do_window('{"after_rst", 10, 0, 1'b1, 1'b0, 10, 10});

    // Chained: start in DONE opens the next window with no idle gap.
    do_window('{"chain_a", 5, 0, 1'b1, 1'b0, 5, 5});
    do_window('{"chain_b", 20, 1, 1'b1, 1'b0, 10, 20});
    after_done("chain_b");

    // iStop/iBit in IDLE are ignored.
    bus.iStop = 1'b1;
    bus.iBit  = 1'b1;
    repeat (3) @(negedge clk);
    check("idle ignore valid", int'(bus.oValid), 0);
    check("idle ignore oC", int'(bus.oC), 10);
    bus.iStop = 1'b0;
    bus.iBit  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
